// File: rtl/mips_exec_controller.sv
// mips_exec_controller: loads a program into the pipeline's instruction memory,
// releases the pipeline from reset and runs it freely or one step at a time.
// When the halt word reaches IF/ID, it drains the pipeline and then freezes it.
module mips_exec_controller #(
  parameter int unsigned    LEN               = 32,
  parameter int unsigned    RAM_DEPTH_PROGRAM = 32,
  parameter logic [LEN-1:0] HALT_WORD         = 32'hFFFFFFFF,
  parameter int unsigned    DRAIN_CYCLES      = 4,
  parameter int unsigned    NB_CYCLE_CNT      = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load_valid,
  input  logic [LEN-1:0]          i_load_data,
  output logic                    o_load_ready,
  input  logic                    i_start,
  input  logic                    i_mode_step,
  input  logic                    i_step,
  input  logic [LEN-1:0]          i_if_id_instr,
  output logic                    o_preload_flag,
  output logic [LEN-1:0]          o_preload_address,
  output logic [LEN-1:0]          o_preload_instruction,
  output logic                    o_cpu_rst,
  output logic                    o_cpu_enable,
  output logic [NB_CYCLE_CNT-1:0] o_cycle_count,
  output logic [1:0]              o_state,
  output logic                    o_done,
  output logic                    o_load_error
);

  localparam int unsigned    DW        = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [LEN-1:0] LAST_ADDR = LEN'(RAM_DEPTH_PROGRAM - 1);
  localparam logic [DW-1:0]  DRAIN_INIT = DW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_READY = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [LEN-1:0]          wr_ptr_q, wr_ptr_d;
  logic                    preload_flag_q, preload_flag_d;
  logic [LEN-1:0]          preload_addr_q, preload_addr_d;
  logic [LEN-1:0]          preload_instr_q, preload_instr_d;
  logic                    load_error_q, load_error_d;
  logic                    step_mode_q, step_mode_d;
  logic                    step_prev_q, step_prev_d;
  logic                    cpu_rst_q, cpu_rst_d;
  logic                    enable_q, enable_d;
  logic                    done_q, done_d;
  logic                    halt_seen_q, halt_seen_d;
  logic [DW-1:0]           drain_q, drain_d;
  logic [NB_CYCLE_CNT-1:0] count_q, count_d;
  logic                    step_edge;

  // Next-state and registered-output logic for the whole sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    preload_flag_d  = 1'b0;
    preload_addr_d  = preload_addr_q;
    preload_instr_d = preload_instr_q;
    load_error_d    = load_error_q;
    step_mode_d     = step_mode_q;
    step_prev_d     = i_step;
    cpu_rst_d       = cpu_rst_q;
    halt_seen_d     = halt_seen_q;
    drain_d         = drain_q;
    count_d         = count_q;
    step_edge       = i_step & ~step_prev_q;

    unique case (state_q)
      ST_LOAD: begin
        if (i_load_valid) begin
          preload_flag_d  = 1'b1;
          preload_addr_d  = wr_ptr_q;
          preload_instr_d = i_load_data;
          wr_ptr_d        = wr_ptr_q + 1'b1;
          if (i_load_data == HALT_WORD) begin
            state_d = ST_READY;
          end else if (wr_ptr_q == LAST_ADDR) begin
            state_d      = ST_READY;
            load_error_d = 1'b1;
          end
        end
      end
      ST_READY: begin
        if (i_start) begin
          state_d     = ST_EXEC;
          step_mode_d = i_mode_step;
          cpu_rst_d   = 1'b1;
        end
      end
      ST_EXEC: begin
        // Work is done only on cycles where the pipeline actually advances.
        if (enable_q) begin
          if (count_q != '1) count_d = count_q + 1'b1;
          if (halt_seen_q) begin
            drain_d = drain_q - 1'b1;
            if (drain_q == DW'(1)) state_d = ST_DONE;
          end else if (i_if_id_instr == HALT_WORD) begin
            halt_seen_d = 1'b1;
            drain_d     = DRAIN_INIT;
          end
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_LOAD;
    endcase

    // Step pulses only count once already executing, so an edge coinciding with start is dropped.
    enable_d = (state_d == ST_EXEC) &&
               (!step_mode_d || ((state_q == ST_EXEC) && step_edge));
    done_d   = (state_d == ST_DONE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!i_rst) begin
      state_q         <= ST_LOAD;
      wr_ptr_q        <= '0;
      preload_flag_q  <= 1'b0;
      preload_addr_q  <= '0;
      preload_instr_q <= '0;
      load_error_q    <= 1'b0;
      step_mode_q     <= 1'b0;
      step_prev_q     <= 1'b0;
      cpu_rst_q       <= 1'b0;
      enable_q        <= 1'b0;
      done_q          <= 1'b0;
      halt_seen_q     <= 1'b0;
      drain_q         <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      preload_flag_q  <= preload_flag_d;
      preload_addr_q  <= preload_addr_d;
      preload_instr_q <= preload_instr_d;
      load_error_q    <= load_error_d;
      step_mode_q     <= step_mode_d;
      step_prev_q     <= step_prev_d;
      cpu_rst_q       <= cpu_rst_d;
      enable_q        <= enable_d;
      done_q          <= done_d;
      halt_seen_q     <= halt_seen_d;
      drain_q         <= drain_d;
      count_q         <= count_d;
    end
  end

  assign o_load_ready          = (state_q == ST_LOAD);
  assign o_state               = state_q;
  assign o_preload_flag        = preload_flag_q;
  assign o_preload_address     = preload_addr_q;
  assign o_preload_instruction = preload_instr_q;
  assign o_cpu_rst             = cpu_rst_q;
  assign o_cpu_enable          = enable_q;
  assign o_cycle_count         = count_q;
  assign o_done                = done_q;
  assign o_load_error          = load_error_q;

endmodule

// File: tb/tb_mips_exec_controller.sv
// Directed bench for mips_exec_controller: load, run, step, halt drain, errors, reset abort.
module tb_mips_exec_controller;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_load_valid = 1'b0;
  logic [31:0] i_load_data = '0;
  logic        o_load_ready;
  logic        i_start = 1'b0;
  logic        i_mode_step = 1'b0;
  logic        i_step = 1'b0;
  logic [31:0] i_if_id_instr = '0;
  logic        o_preload_flag;
  logic [31:0] o_preload_address;
  logic [31:0] o_preload_instruction;
  logic        o_cpu_rst;
  logic        o_cpu_enable;
  logic [31:0] o_cycle_count;
  logic [1:0]  o_state;
  logic        o_done;
  logic        o_load_error;

  int checks = 0;
  int errors = 0;

  mips_exec_controller dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_load_valid          (i_load_valid),
    .i_load_data           (i_load_data),
    .o_load_ready          (o_load_ready),
    .i_start               (i_start),
    .i_mode_step           (i_mode_step),
    .i_step                (i_step),
    .i_if_id_instr         (i_if_id_instr),
    .o_preload_flag        (o_preload_flag),
    .o_preload_address     (o_preload_address),
    .o_preload_instruction (o_preload_instruction),
    .o_cpu_rst             (o_cpu_rst),
    .o_cpu_enable          (o_cpu_enable),
    .o_cycle_count         (o_cycle_count),
    .o_state               (o_state),
    .o_done                (o_done),
    .o_load_error          (o_load_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b0; i_load_valid = 1'b0; i_start = 1'b0; i_step = 1'b0;
    i_mode_step = 1'b0; i_if_id_instr = '0;
    tick(); tick();
    i_rst = 1'b1;
  endtask

  // Present one word for a single cycle and check the resulting preload pulse.
  task automatic load_word(input logic [31:0] w, input logic [31:0] addr);
    i_load_valid = 1'b1;
    i_load_data  = w;
    tick();
    i_load_valid = 1'b0;
    check("pl_flag", 64'(o_preload_flag), 64'd1);
    check("pl_addr", 64'(o_preload_address), 64'(addr));
    check("pl_data", 64'(o_preload_instruction), 64'(w));
  endtask

  task automatic start_exec(input logic step_mode);
    i_mode_step = step_mode;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  int ena_cnt;
  int pulses;

  initial begin
    // Reset state
    do_reset();
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_ready", 64'(o_load_ready), 64'd1);
    check("rst_cpu_rst", 64'(o_cpu_rst), 64'd0);
    check("rst_enable", 64'(o_cpu_enable), 64'd0);
    check("rst_count", 64'(o_cycle_count), 64'd0);
    check("rst_flags", {62'd0, o_done, o_load_error}, 64'd0);

    // i_start while loading is ignored
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    check("start_in_load_state", 64'(o_state), 64'd0);
    check("start_in_load_cpu_rst", 64'(o_cpu_rst), 64'd0);

    // Back-to-back load of a three-word program ending in HALT
    i_load_valid = 1'b1;
    i_load_data = 32'h20010005;
    tick();
    check("b2b_flag0", 64'(o_preload_flag), 64'd1);
    check("b2b_addr0", 64'(o_preload_address), 64'd0);
    check("b2b_data0", 64'(o_preload_instruction), 64'h20010005);
    i_load_data = 32'h20020003;
    tick();
    check("b2b_flag1", 64'(o_preload_flag), 64'd1);
    check("b2b_addr1", 64'(o_preload_address), 64'd1);
    check("b2b_data1", 64'(o_preload_instruction), 64'h20020003);
    i_load_data = HALT;
    tick();
    check("b2b_flag2", 64'(o_preload_flag), 64'd1);
    check("b2b_addr2", 64'(o_preload_address), 64'd2);
    check("b2b_data2", 64'(o_preload_instruction), 64'(HALT));
    check("load_to_ready", 64'(o_state), 64'd1);
    // Valid held into READY must not produce a write
    i_load_data = 32'h12345678;
    tick(); tick();
    i_load_valid = 1'b0;
    check("ready_ignores_valid_flag", 64'(o_preload_flag), 64'd0);
    check("ready_ignores_valid_state", 64'(o_state), 64'd1);
    check("ready_load_ready", 64'(o_load_ready), 64'd0);
    check("ready_no_error", 64'(o_load_error), 64'd0);
    check("ready_cpu_rst", 64'(o_cpu_rst), 64'd0);

    // Run mode: halt appears on the 5th enabled cycle and stays there
    start_exec(1'b0);
    check("exec_state", 64'(o_state), 64'd2);
    check("exec_cpu_rst", 64'(o_cpu_rst), 64'd1);
    ena_cnt = 0;
    for (int c = 0; c < 40 && !o_done; c++) begin
      if (o_cpu_enable) ena_cnt++;
      i_if_id_instr = (o_cpu_enable && ena_cnt >= 5) ? HALT : 32'h00000000;
      tick();
    end
    check("run_enabled_cycles", 64'(ena_cnt), 64'd9);
    check("run_count", 64'(o_cycle_count), 64'd9);
    check("run_done", 64'(o_done), 64'd1);
    check("run_enable_off", 64'(o_cpu_enable), 64'd0);
    check("run_state_done", 64'(o_state), 64'd3);
    check("run_cpu_rst_done", 64'(o_cpu_rst), 64'd1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick();
    check("done_count_frozen", 64'(o_cycle_count), 64'd9);
    check("done_sticky", {62'd0, o_state == 2'd3, o_done}, 64'd3);

    // Step mode: idle, then three edges each held high for several cycles
    do_reset();
    load_word(32'h20010005, 32'd0);
    load_word(HALT, 32'd1);
    start_exec(1'b1);
    ena_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_cpu_enable) ena_cnt++;
      tick();
    end
    check("step_idle_enables", 64'(ena_cnt), 64'd0);
    check("step_idle_count", 64'(o_cycle_count), 64'd0);
    pulses = 0;
    for (int s = 0; s < 3; s++) begin
      i_step = 1'b1;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (o_cpu_enable) pulses++;
      end
      i_step = 1'b0;
      for (int c = 0; c < 2; c++) begin
        tick();
        if (o_cpu_enable) pulses++;
      end
    end
    check("step_pulses", 64'(pulses), 64'd3);
    check("step_count", 64'(o_cycle_count), 64'd3);
    check("step_still_exec", 64'(o_state), 64'd2);

    // Memory filled without HALT: error and READY
    do_reset();
    i_load_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      i_load_data = 32'h10000000 + 32'(i);
      tick();
    end
    i_load_valid = 1'b0;
    check("fill_last_addr", 64'(o_preload_address), 64'd31);
    check("fill_last_data", 64'(o_preload_instruction), 64'h1000001F);
    check("fill_state", 64'(o_state), 64'd1);
    check("fill_error", 64'(o_load_error), 64'd1);
    tick(); tick();
    check("fill_error_sticky", 64'(o_load_error), 64'd1);

    // Reset abort during execution at count 6
    do_reset();
    load_word(HALT, 32'd0);
    start_exec(1'b0);
    for (int c = 0; c < 6; c++) tick();
    check("abort_count_before", 64'(o_cycle_count), 64'd6);
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    check("abort_state", 64'(o_state), 64'd0);
    check("abort_count", 64'(o_cycle_count), 64'd0);
    check("abort_cpu_rst", 64'(o_cpu_rst), 64'd0);
    check("abort_enable", 64'(o_cpu_enable), 64'd0);
    load_word(32'h20030001, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
